// File: rtl/mskaes_rcon_inv.sv
// Bidirectional AES round-constant sequencer for the masked key schedule.
// Steps rcon forward (xtime) for key expansion or backward (multiply by x^-1)
// for on-the-fly decryption key unrolling.
// The constant is presented as the trivial sharing (v, 0, ..., 0).
module mskaes_rcon_inv #(
  parameter int unsigned D = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               inverse_i,
  input  logic               step_i,
  input  logic               mask_rcon_i,
  output logic [8*D-1:0]     sh_rcon_o,
  output logic [3:0]         round_o,
  output logic               last_round_o,
  output logic               busy_o
);

  localparam int unsigned RconW  = 8;
  localparam int unsigned RoundW = 4;
  localparam int unsigned ShW    = RconW * D;

  localparam logic [RconW-1:0]  RconFirstFwd = 8'h01;
  localparam logic [RconW-1:0]  RconFirstInv = 8'h36;
  localparam logic [RconW-1:0]  AesPoly      = 8'h1b;
  localparam logic [RoundW-1:0] LastRound    = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [RconW-1:0]     rcon_q, rcon_d;
  logic [RoundW-1:0]    round_q, round_d;
  logic                 dir_q, dir_d;

  logic [RconW-1:0]     rcon_fwd;
  logic [RconW-1:0]     rcon_inv;
  logic [RconW-1:0]     rcon_next;
  logic [RconW-1:0]     out_val;
  logic                 at_last;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  always_comb begin
    rcon_fwd = {rcon_q[RconW-2:0], 1'b0};
    if (rcon_q[RconW-1]) begin
      rcon_fwd = rcon_fwd ^ AesPoly;
    end
  end

  // Multiply by x^-1: fold the polynomial back in when bit 0 is set.
  always_comb begin
    rcon_inv = {1'b0, rcon_q[RconW-1:1]};
    if (rcon_q[0]) begin
      rcon_inv = {1'b1, (rcon_q[RconW-1:1] ^ AesPoly[RconW-1:1])};
    end
  end

  assign rcon_next = dir_q ? rcon_inv : rcon_fwd;
  assign at_last   = (round_q == LastRound);

  // Control FSM next-state: start always wins, step advances only while running.
  always_comb begin
    state_d = state_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    dir_d   = dir_q;

    if (start_i) begin
      state_d = RUN;
      rcon_d  = inverse_i ? RconFirstInv : RconFirstFwd;
      round_d = '0;
      dir_d   = inverse_i;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Steps are ignored while idle.
        end
        RUN: begin
          if (step_i) begin
            if (at_last) begin
              state_d = IDLE;
            end else begin
              rcon_d  = rcon_next;
              round_d = round_q + RoundW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with asynchronous abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcon_q  <= RconFirstFwd;
      round_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      dir_q   <= dir_d;
    end
  end

  assign busy_o       = (state_q == RUN);
  assign last_round_o = busy_o & at_last;
  assign round_o      = round_q;
  assign out_val      = (busy_o & mask_rcon_i) ? rcon_q : '0;

  // Share 0 carries the value, interleaved as bit i of share j at D*i+j.
  always_comb begin
    sh_rcon_o = '0;
    for (int unsigned i = 0; i < RconW; i++) begin
      sh_rcon_o[D*i] = out_val[i];
    end
  end

  logic unused_shw;
  assign unused_shw = ^ShW;

endmodule

// File: tb/tb_mskaes_rcon_inv.sv
// Directed self-checking bench for mskaes_rcon_inv (three shares).
module tb_mskaes_rcon_inv;

  localparam int unsigned D  = 3;
  localparam int unsigned SW = 8 * D;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic          inverse_i;
  logic          step_i;
  logic          mask_rcon_i;
  logic [SW-1:0] sh_rcon_o;
  logic [3:0]    round_o;
  logic          last_round_o;
  logic          busy_o;

  int tests;
  int fails;

  logic [7:0] fwd_seq [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [7:0] inv_seq [10] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  mskaes_rcon_inv #(.D(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .inverse_i    (inverse_i),
    .step_i       (step_i),
    .mask_rcon_i  (mask_rcon_i),
    .sh_rcon_o    (sh_rcon_o),
    .round_o      (round_o),
    .last_round_o (last_round_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected interleaved vector: value bits on share 0, other shares zero.
  function automatic logic [SW-1:0] spread(input logic [7:0] v);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[D*i] = v[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; inverse_i = 1'b0; step_i = 1'b0; mask_rcon_i = 1'b1;
    tick();
    tests++;
    if (busy_o !== 1'b0 || sh_rcon_o !== '0 || round_o !== 4'd0 || last_round_o !== 1'b0) begin
      fails++;
      $display("FAIL reset: busy=%b sh=%h round=%0d last=%b, want 0 0 0 0",
               busy_o, sh_rcon_o, round_o, last_round_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    inverse_i = 1'b0; mask_rcon_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (sh_rcon_o !== spread(fwd_seq[k]) || round_o !== 4'(k) || busy_o !== 1'b1 ||
          last_round_o !== (k == 9)) begin
        fails++;
        $display("FAIL forward[%0d]: sh=%h round=%0d busy=%b last=%b, want sh=%h round=%0d busy=1 last=%b",
                 k, sh_rcon_o, round_o, busy_o, last_round_o, spread(fwd_seq[k]), k, (k == 9));
      end
      step_i = 1'b1;
      tick();
    end
    step_i = 1'b0;
    tests++;
    if (busy_o !== 1'b0 || sh_rcon_o !== '0 || last_round_o !== 1'b0) begin
      fails++;
      $display("FAIL forward_end: busy=%b sh=%h last=%b, want 0 0 0", busy_o, sh_rcon_o, last_round_o);
    end
  endtask

  task automatic test_inverse();
    inverse_i = 1'b1; mask_rcon_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0; inverse_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int g = 0; g <= k % 4; g++) begin
        tests++;
        if (sh_rcon_o !== spread(inv_seq[k]) || round_o !== 4'(k) || busy_o !== 1'b1) begin
          fails++;
          $display("FAIL inverse[%0d.%0d]: sh=%h round=%0d busy=%b, want sh=%h round=%0d busy=1",
                   k, g, sh_rcon_o, round_o, busy_o, spread(inv_seq[k]), k);
        end
        if (g < k % 4) begin
          step_i = 1'b0;
          tick();
        end
      end
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
    end
    tests++;
    if (busy_o !== 1'b0 || sh_rcon_o !== '0) begin
      fails++;
      $display("FAIL inverse_end: busy=%b sh=%h, want 0 0", busy_o, sh_rcon_o);
    end
  endtask

  task automatic test_idle_gating();
    mask_rcon_i = 1'b1;
    step_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (busy_o !== 1'b0 || sh_rcon_o !== '0 || round_o !== 4'd9) begin
        fails++;
        $display("FAIL idle_step[%0d]: busy=%b sh=%h round=%0d, want 0 0 9", k, busy_o, sh_rcon_o, round_o);
      end
    end
    step_i = 1'b0;
    inverse_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      mask_rcon_i = k[0];
      #1;
      tests++;
      if (sh_rcon_o !== (k[0] ? spread(fwd_seq[k]) : '0) || round_o !== 4'(k)) begin
        fails++;
        $display("FAIL gating[%0d]: sh=%h round=%0d, want sh=%h round=%0d",
                 k, sh_rcon_o, round_o, (k[0] ? spread(fwd_seq[k]) : '0), k);
      end
      mask_rcon_i = ~k[0];
      #1;
      tests++;
      if (sh_rcon_o !== (k[0] ? '0 : spread(fwd_seq[k]))) begin
        fails++;
        $display("FAIL gating_same_cycle[%0d]: sh=%h, want %h",
                 k, sh_rcon_o, (k[0] ? '0 : spread(fwd_seq[k])));
      end
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
    end
    mask_rcon_i = 1'b1;
  endtask

  task automatic test_restart();
    inverse_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    step_i = 1'b1;
    repeat (4) tick();
    step_i = 1'b0;
    tests++;
    if (sh_rcon_o !== spread(8'h10) || round_o !== 4'd4) begin
      fails++;
      $display("FAIL restart_pre: sh=%h round=%0d, want %h 4", sh_rcon_o, round_o, spread(8'h10));
    end
    start_i = 1'b1; inverse_i = 1'b1; step_i = 1'b1;
    tick();
    start_i = 1'b0; inverse_i = 1'b0; step_i = 1'b0;
    tests++;
    if (sh_rcon_o !== spread(8'h36) || round_o !== 4'd0 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL restart: sh=%h round=%0d busy=%b, want %h 0 1", sh_rcon_o, round_o, busy_o, spread(8'h36));
    end
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    tests++;
    if (sh_rcon_o !== spread(8'h1b) || round_o !== 4'd1) begin
      fails++;
      $display("FAIL restart_dir: sh=%h round=%0d, want %h 1", sh_rcon_o, round_o, spread(8'h1b));
    end
  endtask

  task automatic test_async_reset();
    inverse_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    step_i = 1'b1;
    repeat (6) tick();
    step_i = 1'b0;
    tests++;
    if (sh_rcon_o !== spread(8'h40) || round_o !== 4'd6) begin
      fails++;
      $display("FAIL areset_pre: sh=%h round=%0d, want %h 6", sh_rcon_o, round_o, spread(8'h40));
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy_o !== 1'b0 || sh_rcon_o !== '0 || round_o !== 4'd0) begin
      fails++;
      $display("FAIL areset: busy=%b sh=%h round=%0d, want 0 0 0", busy_o, sh_rcon_o, round_o);
    end
    tick();
    rst_n = 1'b1;
    start_i = 1'b1; inverse_i = 1'b0;
    tick();
    start_i = 1'b0;
    tests++;
    if (sh_rcon_o !== spread(8'h01) || round_o !== 4'd0 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL areset_resume: sh=%h round=%0d busy=%b, want %h 0 1", sh_rcon_o, round_o, busy_o, spread(8'h01));
    end
  endtask

  task automatic test_share_layout();
    inverse_i = 1'b0; mask_rcon_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    step_i = 1'b1;
    repeat (8) tick();
    step_i = 1'b0;
    // 0x1b -> bits 0,1,3,4 -> indices 0,3,9,12 on share 0.
    tests++;
    if (sh_rcon_o !== 24'h001209 || round_o !== 4'd8 || last_round_o !== 1'b0) begin
      fails++;
      $display("FAIL share_layout: sh=%h round=%0d last=%b, want 001209 8 0", sh_rcon_o, round_o, last_round_o);
    end
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    // 0x36 -> bits 1,2,4,5 -> indices 3,6,12,15.
    tests++;
    if (sh_rcon_o !== 24'h009048 || last_round_o !== 1'b1) begin
      fails++;
      $display("FAIL share_layout_last: sh=%h last=%b, want 009048 1", sh_rcon_o, last_round_o);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_forward();
    test_inverse();
    test_idle_gating();
    test_restart();
    test_async_reset();
    test_share_layout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
